kalman_filter_mc: RTL and testbench

//   Multi-channel 1D Kalman filter (A=1, B=0, H=1), fixed point; successor to the single-channel filter.

---
 rtl/kalman_filter_mc_if.sv | 29 ++
 rtl/kalman_filter_mc.sv | 204 ++++++++++++++++++++
 tb/tb_kalman_filter_mc.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/kalman_filter_mc_if.sv
// Measurement-in / estimate-out bus of the multi-channel Kalman filter.
// The master side is the sensor front-end; the slave side is the filter.
interface kalman_filter_mc_if #(
    parameter int STATE_BITS = 16,
    parameter int VAR_BITS   = 48,
    parameter int CW         = 2
);
    logic                         z_valid;
    logic                         z_ready;
    logic signed [STATE_BITS-1:0] z_in;
    logic        [CW-1:0]         z_ch;
    logic        [VAR_BITS-1:0]   q_var;
    logic        [VAR_BITS-1:0]   r_var;
    logic                         x_valid;
    logic signed [STATE_BITS-1:0] x_out;
    logic        [CW-1:0]         x_ch;
    logic        [VAR_BITS-1:0]   p_out;
    logic                         ch_err;

    modport master (
        output z_valid, z_in, z_ch, q_var, r_var,
        input  z_ready, x_valid, x_out, x_ch, p_out, ch_err
    );

    modport slave (
        input  z_valid, z_in, z_ch, q_var, r_var,
        output z_ready, x_valid, x_out, x_ch, p_out, ch_err
    );
endinterface

// File: rtl/kalman_filter_mc.sv
// Multi-channel 1D Kalman filter (A=1, B=0, H=1) sharing one datapath and a restoring divider.
// Optional macro KF_CH_CLEAR_EN adds ch_clear/ch_clear_idx for per-channel reinitialisation.
module kalman_filter_mc #(
    parameter  int CHANNELS   = 4,
    parameter  int STATE_BITS = 16,
    parameter  int VAR_BITS   = 48,
    parameter  int VAR_Q      = 30,
    parameter  int K_Q        = 16,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic          clk,
    input  logic          rst,
`ifdef KF_CH_CLEAR_EN
    input  logic          ch_clear,
    input  logic [CW-1:0] ch_clear_idx,
`endif
    kalman_filter_mc_if.slave bus
);

    localparam int KW      = K_Q + 1;
    localparam int CNT_W   = (K_Q > 0) ? $clog2(K_Q + 1) : 1;
    localparam int RW      = STATE_BITS + 1;
    localparam int PW      = K_Q + STATE_BITS + 3;
    localparam int VW      = KW + VAR_BITS + 1;
    localparam int NCH_POW = 1 << CW;

    localparam logic [NCH_POW-1:0]  CH_MASK  = {NCH_POW{1'b1}} >> (NCH_POW - CHANNELS);
    localparam logic [VAR_BITS-1:0] P_INIT   = VAR_BITS'(1) << VAR_Q;
    localparam logic [KW-1:0]       K_ONE    = KW'(1) << K_Q;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(K_Q);
    localparam logic [PW-1:0]       HALF_P   = PW'(1) << (K_Q - 1);
    localparam logic [VW-1:0]       HALF_V   = VW'(1) << (K_Q - 1);
    localparam logic signed [PW-1:0] X_MAX   = {{(PW-STATE_BITS+1){1'b0}}, {(STATE_BITS-1){1'b1}}};
    localparam logic signed [PW-1:0] X_MIN   = ~X_MAX;

    typedef enum logic [1:0] {IDLE, PREDICT, DIVIDE, UPDATE} state_t;

    state_t state, state_nx;

    logic signed [STATE_BITS-1:0] x_mem [CHANNELS];
    logic        [VAR_BITS-1:0]   p_mem [CHANNELS];

    logic                         accept, ch_ok;
    logic                         clr_hit;
    logic        [CW-1:0]         clr_idx;
    logic signed [STATE_BITS-1:0] z_s, x_s;
    logic        [CW-1:0]         ch_s;
    logic        [VAR_BITS-1:0]   q_s, r_s, pm_s;
    logic        [VAR_BITS:0]     den_s;
    logic        [VAR_BITS+1:0]   rem;
    logic        [KW-1:0]         quot;
    logic        [CNT_W-1:0]      cnt;
    logic                         wb_kill;

    logic        [VAR_BITS:0]     p_sum;
    logic        [VAR_BITS-1:0]   pm_c;
    logic        [VAR_BITS:0]     den_c;
    logic        [VAR_BITS+1:0]   trial;
    logic                         take;
    logic        [KW-1:0]         k_eff, omk;
    logic signed [RW-1:0]         res;
    logic signed [PW-1:0]         k_ext, res_ext, prod, delta, x_sum;
    logic        [PW-1:0]         mag, rmag;
    logic signed [STATE_BITS-1:0] x_new;
    logic        [VW-1:0]         p_prod, p_rnd;
    logic        [VAR_BITS-1:0]   p_new;

    assign bus.z_ready = (state == IDLE);
    assign accept      = bus.z_valid && bus.z_ready;
    assign ch_ok       = CH_MASK[bus.z_ch];

`ifdef KF_CH_CLEAR_EN
    assign clr_hit = ch_clear && CH_MASK[ch_clear_idx];
    assign clr_idx = ch_clear_idx;
`else
    assign clr_hit = 1'b0;
    assign clr_idx = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && ch_ok) state_nx = PREDICT;
            PREDICT: state_nx = DIVIDE;
            DIVIDE:  if (cnt == CNT_LAST) state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        p_sum = {1'b0, p_mem[ch_s]} + {1'b0, q_s};
        pm_c  = p_sum[VAR_BITS] ? '1 : p_sum[VAR_BITS-1:0];
        den_c = {1'b0, pm_c} + {1'b0, r_s};

        // The first quotient bit (weight 2^K_Q) compares Pm itself; later bits shift the remainder.
        trial = (cnt == '0) ? rem : {rem[VAR_BITS:0], 1'b0};
        take  = (trial >= {1'b0, den_s});

        k_eff   = (den_s == '0) ? K_ONE : quot;
        res     = {z_s[STATE_BITS-1], z_s} - {x_s[STATE_BITS-1], x_s};
        k_ext   = {{(PW-KW){1'b0}}, k_eff};
        res_ext = {{(PW-RW){res[RW-1]}}, res};
        prod    = k_ext * res_ext;

        // Round half away from zero on the magnitude, then restore the sign.
        mag   = prod[PW-1] ? -prod : prod;
        rmag  = (mag + HALF_P) >> K_Q;
        delta = prod[PW-1] ? -rmag : rmag;
        x_sum = {{(PW-STATE_BITS){x_s[STATE_BITS-1]}}, x_s} + delta;
        if (x_sum > X_MAX)      x_new = X_MAX[STATE_BITS-1:0];
        else if (x_sum < X_MIN) x_new = X_MIN[STATE_BITS-1:0];
        else                    x_new = x_sum[STATE_BITS-1:0];

        omk    = K_ONE - k_eff;
        p_prod = {{(VW-KW){1'b0}}, omk} * {{(VW-VAR_BITS){1'b0}}, pm_s};
        p_rnd  = (p_prod + HALF_V) >> K_Q;
        p_new  = (|p_rnd[VW-1:VAR_BITS]) ? '1 : p_rnd[VAR_BITS-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_s         <= '0;
            x_s         <= '0;
            ch_s        <= '0;
            q_s         <= '0;
            r_s         <= '0;
            pm_s        <= '0;
            den_s       <= '0;
            rem         <= '0;
            quot        <= '0;
            cnt         <= '0;
            wb_kill     <= 1'b0;
            bus.x_valid <= 1'b0;
            bus.x_out   <= '0;
            bus.x_ch    <= '0;
            bus.p_out   <= '0;
            bus.ch_err  <= 1'b0;
        end else begin
            bus.x_valid <= 1'b0;
            bus.ch_err  <= accept && !ch_ok;
            case (state)
                IDLE: begin
                    if (accept && ch_ok) begin
                        z_s     <= bus.z_in;
                        ch_s    <= bus.z_ch;
                        q_s     <= bus.q_var;
                        r_s     <= bus.r_var;
                        wb_kill <= 1'b0;
                    end
                end
                PREDICT: begin
                    x_s   <= x_mem[ch_s];
                    pm_s  <= pm_c;
                    den_s <= den_c;
                    rem   <= {1'b0, den_c[VAR_BITS:0] - {1'b0, r_s}};
                    quot  <= '0;
                    cnt   <= '0;
                end
                DIVIDE: begin
                    rem  <= take ? (trial - {1'b0, den_s}) : trial;
                    quot <= {quot[KW-2:0], take};
                    cnt  <= cnt + 1'b1;
                end
                UPDATE: begin
                    bus.x_valid <= 1'b1;
                    bus.x_out   <= x_new;
                    bus.p_out   <= p_new;
                    bus.x_ch    <= ch_s;
                end
                default: ;
            endcase
            // A clear landing on the channel in flight wins over its pending write-back.
            if (clr_hit && (clr_idx == ch_s) && (state != IDLE)) wb_kill <= 1'b1;
        end
    end

    // NOTE: the per-channel banks are small flop arrays whose reset values are architectural, so they are reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                x_mem[c] <= '0;
                p_mem[c] <= P_INIT;
            end
        end else begin
            if ((state == UPDATE) && !wb_kill) begin
                x_mem[ch_s] <= x_new;
                p_mem[ch_s] <= p_new;
            end
            if (clr_hit) begin
                x_mem[clr_idx] <= '0;
                p_mem[clr_idx] <= P_INIT;
            end
        end
    end

endmodule

// File: tb/tb_kalman_filter_mc.sv
// Directed bench for kalman_filter_mc: an arithmetic reference model predicts every output pulse,
// a per-cycle compare process checks handshake and results, and literal values pin the model.
module tb_kalman_filter_mc;

    localparam int CH  = 3;
    localparam int SB  = 16;
    localparam int VB  = 48;
    localparam int VQ  = 30;
    localparam int KQ  = 16;
    localparam int CWB = 2;
    localparam int LAT = KQ + 3;

    localparam longint ONE_K = longint'(1) << KQ;
    localparam longint HALF  = longint'(1) << (KQ - 1);
    localparam longint VMAXL = (longint'(1) << VB) - 1;
    localparam longint P0    = longint'(1) << VQ;
    localparam longint R30   = longint'(1) << 30;

    typedef struct {
        longint x;
        longint p;
        int     ch;
        longint cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    kalman_filter_mc_if #(.STATE_BITS(SB), .VAR_BITS(VB), .CW(CWB)) bus ();

    kalman_filter_mc #(
        .CHANNELS(CH), .STATE_BITS(SB), .VAR_BITS(VB), .VAR_Q(VQ), .K_Q(KQ)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef KF_CH_CLEAR_EN
        .ch_clear(1'b0),
        .ch_clear_idx(2'd0),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc      = 0;
    longint busy_end = 0;
    longint err_cyc  = -1;
    longint mx [CH];
    longint mp [CH];
    exp_t   exp_q [$];
    logic   xv_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
        end
    endtask

    task automatic reset_model();
        for (int c = 0; c < CH; c++) begin
            mx[c] = 0;
            mp[c] = P0;
        end
        exp_q.delete();
        busy_end = 0;
        err_cyc  = -1;
    endtask

    // Called just after the accept edge; cyc then equals the accept edge count.
    task automatic model_accept(input int ch, input longint z, input longint q, input longint r);
        logic [127:0] pm, den, k, pp, vmax;
        longint res, prod, dx, xn;
        if (ch >= CH) begin
            err_cyc = cyc;
            return;
        end
        vmax = 128'(VMAXL);
        pm   = 128'(mp[ch]) + 128'(q);
        if (pm > vmax) pm = vmax;
        den  = pm + 128'(r);
        k    = (den == 0) ? 128'(ONE_K) : ((pm << KQ) / den);
        res  = z - mx[ch];
        prod = longint'(k) * res;
        dx   = (prod >= 0) ? (prod + HALF) / ONE_K : -((-prod + HALF) / ONE_K);
        xn   = mx[ch] + dx;
        if (xn > 32767)  xn = 32767;
        if (xn < -32768) xn = -32768;
        pp = ((128'(ONE_K) - k) * pm + 128'(HALF)) >> KQ;
        if (pp > vmax) pp = vmax;
        mx[ch] = xn;
        mp[ch] = longint'(pp);
        exp_q.push_back('{x: xn, p: longint'(pp), ch: ch, cyc: cyc + LAT});
        busy_end = cyc + LAT;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            xv_exp = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
            check("x_valid", 64'(bus.x_valid), 64'(xv_exp));
            if (xv_exp) begin
                check("x_out", bus.x_out, exp_q[0].x);
                check("p_out", bus.p_out, exp_q[0].p);
                check("x_ch",  64'(bus.x_ch), 64'(exp_q[0].ch));
            end
            if ((exp_q.size() != 0) && (exp_q[0].cyc <= cyc)) void'(exp_q.pop_front());
            check("z_ready", 64'(bus.z_ready), 64'(cyc >= busy_end));
            check("ch_err",  64'(bus.ch_err),  64'(cyc == err_cyc));
        end
    end

    task automatic drive(input int ch, input longint z, input longint q, input longint r);
        bus.z_in  = SB'(z);
        bus.z_ch  = CWB'(ch);
        bus.q_var = VB'(q);
        bus.r_var = VB'(r);
    endtask

    task automatic send(input int ch, input longint z, input longint q, input longint r);
        int   n = 0;
        logic will;
        while ((cyc < busy_end) && (n < 100)) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_wait_timeout", 64'(n < 100), 64'(1));
        drive(ch, z, q, r);
        bus.z_valid = 1'b1;
        will = (cyc >= busy_end);
        @(posedge clk); #1;
        bus.z_valid = 1'b0;
        if (will) model_accept(ch, z, q, r);
    endtask

    task automatic drain();
        int n = 0;
        while (((exp_q.size() != 0) || (cyc <= busy_end)) && (n < 200)) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", 64'(n < 200), 64'(1));
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input longint x, input longint p, input int ch);
        check({tag, "_x"},  bus.x_out, x);
        check({tag, "_p"},  bus.p_out, p);
        check({tag, "_ch"}, 64'(bus.x_ch), 64'(ch));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int dut_acc, mdl_acc, low_cnt;
        logic will;
        bus.z_valid = 1'b0;
        drive(0, 0, 0, 0);
        reset_model();

        repeat (2) @(negedge clk);
        check("rst_z_ready", 64'(bus.z_ready), 64'(1));
        check("rst_x_valid", 64'(bus.x_valid), 64'(0));
        check("rst_ch_err",  64'(bus.ch_err),  64'(0));
        expect_out("rst", 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        send(0, 1000, 0, R30);
        drain();
        expect_out("ch0_first", 500, longint'(1) << 29, 0);

        send(1, -2000, 0, R30);
        drain();
        expect_out("ch1_first", -1000, longint'(1) << 29, 1);

        send(0, 2000, 0, R30);
        drain();
        expect_out("ch0_third", 1000, 357916672, 0);

        send(0, 1200, 0, 0);
        drain();
        expect_out("ch0_k_one", 1200, 0, 0);

        send(0, -300, 0, 0);
        drain();
        expect_out("ch0_den_zero", -300, 0, 0);

        send(1, 3, longint'(1) << 28, R30);
        drain();

        send(2, 32767, 0, 0);
        drain();
        expect_out("ch2_max", 32767, 0, 2);

        send(2, -32768, VMAXL, VMAXL);
        drain();
        expect_out("ch2_min_res", -1, longint'(1) << 47, 2);

        send(2, 100, VMAXL, VMAXL);
        drain();
        expect_out("ch2_pm_sat", 50, longint'(1) << 47, 2);

        send(3, 1234, 0, 0);
        repeat (3) @(posedge clk); #1;
        send(1, -500, 1000, 1 << 20);
        drain();
        send(0, 700, 0, R30);
        drain();

        dut_acc = 0;
        mdl_acc = 0;
        low_cnt = 0;
        drive(2, 100, longint'(1) << 20, longint'(1) << 25);
        bus.z_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            will = (cyc >= busy_end);
            if (bus.z_ready) dut_acc++;
            else             low_cnt++;
            @(posedge clk); #1;
            if (will) begin
                model_accept(2, 100, longint'(1) << 20, longint'(1) << 25);
                mdl_acc++;
            end
        end
        bus.z_valid = 1'b0;
        check("hold_dut_accepts",   64'(dut_acc), 64'(2));
        check("hold_model_accepts", 64'(mdl_acc), 64'(2));
        check("hold_ready_low",     64'(low_cnt), 64'(2 * LAT));
        drain();

        send(0, 5000, 0, R30);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        reset_model();
        @(negedge clk);
        check("midrst_x_valid", 64'(bus.x_valid), 64'(0));
        check("midrst_z_ready", 64'(bus.z_ready), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (LAT + 2) begin
            @(posedge clk); #1;
        end
        send(0, 1000, 0, R30);
        drain();
        expect_out("after_rst", 500, longint'(1) << 29, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
